// File: rtl/conv_inst_rd_agen_if.sv
// Bus bundle for the conv instruction read address generator: instruction stream in,
// feature-SRAM read port, and the flow-controlled read-data stream out.
interface conv_inst_rd_agen_if #(
  parameter int unsigned IRW = 31,
  parameter int unsigned IN  = 3,
  parameter int unsigned AW  = 14,
  parameter int unsigned DW  = 64
);
  logic [IRW*IN-1:0] m_inst;
  logic              m_valid;
  logic              m_ready;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic [DW-1:0]     mem_rd_data;
  logic [DW-1:0]     s_data;
  logic              s_last;
  logic              s_valid;
  logic              s_ready;

  modport slave (
    input  m_inst, m_valid, mem_rd_data, s_ready,
    output m_ready, mem_rd_en, mem_rd_addr, s_data, s_last, s_valid
  );

  modport master (
    output m_inst, m_valid, mem_rd_data, s_ready,
    input  m_ready, mem_rd_en, mem_rd_addr, s_data, s_last, s_valid
  );
endinterface

// File: rtl/conv_inst_rd_agen.sv
// Expands conv instructions into sequential feature-SRAM reads and returns the data
// through a small FIFO; issue is credit-limited so read data is never dropped.
module conv_inst_rd_agen #(
  parameter int unsigned IRW    = 31,
  parameter int unsigned IN     = 3,
  parameter int unsigned AW     = 14,
  parameter int unsigned DW     = 64,
  parameter int unsigned FDEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  conv_inst_rd_agen_if.slave bus_io
);
  localparam int unsigned PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int unsigned CW = $clog2(FDEPTH + 1);
  localparam logic [CW:0] DepthC = FDEPTH[CW:0];

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e          state_q;
  logic [AW-1:0]   cur_q;
  logic [7:0]      rem_q;
  logic            pend_q;
  logic            pend_last_q;
  logic [DW:0]     fifo_q [FDEPTH];
  logic [PW-1:0]   wptr_q;
  logic [PW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  logic            fc;
  logic [AW-1:0]   base;
  logic [6:0]      dim0;
  logic [7:0]      inst_len;
  logic [CW:0]     occ;
  logic            issue;
  logic            last_issue;
  logic            m_ready;
  logic            accept;
  logic            push;
  logic            pop;
  logic            unused_inst;

  assign fc          = bus_io.m_inst[0];
  assign base        = bus_io.m_inst[8 +: AW];
  assign dim0        = bus_io.m_inst[22 +: 7];
  assign unused_inst = ^{bus_io.m_inst[IRW*IN-1:29], bus_io.m_inst[7:1]};

  always_comb begin
    inst_len = 8'd1;
    if (!fc) inst_len = (dim0 == 7'd0) ? 8'd128 : {1'b0, dim0};
  end

  // Outstanding words (queued plus the read still in flight) bound the issue credit.
  assign occ        = {1'b0, count_q} + {{CW{1'b0}}, pend_q};
  assign issue      = (state_q == StIssue) && (occ < DepthC);
  assign last_issue = issue && (rem_q == 8'd1);
  assign m_ready    = rst_n && ((state_q == StIdle) || last_issue);
  assign accept     = bus_io.m_valid && m_ready;

  assign push = pend_q;
  assign pop  = (count_q != '0) && bus_io.s_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign bus_io.m_ready     = m_ready;
  assign bus_io.mem_rd_en   = issue;
  assign bus_io.mem_rd_addr = cur_q;
  assign bus_io.s_valid     = (count_q != '0);
  assign bus_io.s_last      = fifo_q[rptr_q][DW];
  assign bus_io.s_data      = fifo_q[rptr_q][DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      rem_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      for (int unsigned i = 0; i < FDEPTH; i++) fifo_q[i] <= '0;
    end else begin
      pend_q      <= issue;
      pend_last_q <= last_issue;
      count_q     <= count_d;

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cur_q   <= base;
            rem_q   <= inst_len;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (issue) begin
            if (accept) begin
              // Reload on the final issue so consecutive instructions have no bubble.
              cur_q <= base;
              rem_q <= inst_len;
            end else begin
              cur_q <= cur_q + AW'(1);
              rem_q <= rem_q - 8'd1;
              if (rem_q == 8'd1) state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (push) begin
        fifo_q[wptr_q] <= {pend_last_q, bus_io.mem_rd_data};
        wptr_q         <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
    end
  end
endmodule

// File: tb/tb_conv_inst_rd_agen.sv
// Directed bench for conv_inst_rd_agen with an address/word scoreboard and SRAM model.
module tb_conv_inst_rd_agen;
  localparam int unsigned IRW = 31;
  localparam int unsigned IN  = 3;
  localparam int unsigned AW  = 14;
  localparam int unsigned DW  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_inst_rd_agen_if #(.IRW(IRW), .IN(IN), .AW(AW), .DW(DW)) bus ();

  conv_inst_rd_agen #(.IRW(IRW), .IN(IN), .AW(AW), .DW(DW), .FDEPTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rd_count = 0;
  int first_rd = -1;
  int last_rd = -1;
  int first_sv = -1;
  int acc_cyc = 0;

  logic [AW-1:0] exp_addr [$];
  logic [DW:0]   exp_word [$];

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return {18'h2A5A5, a ^ 14'h1555, 18'(a) * 18'd7, a};
  endfunction

  // SRAM model: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_f(bus.mem_rd_addr);
    else               bus.mem_rd_data <= {$urandom, $urandom};
  end

  task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.mem_rd_en) begin
        rd_count++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        if (exp_addr.size() == 0) check("rd_extra", 65'(exp_addr.size()), 65'd1);
        else check("rd_addr", 65'(bus.mem_rd_addr), 65'(exp_addr.pop_front()));
      end
      if (bus.s_valid) begin
        if (first_sv < 0) first_sv = cyc;
        if (bus.s_ready) begin
          if (exp_word.size() == 0) check("word_extra", 65'(exp_word.size()), 65'd1);
          else check("word", {bus.s_last, bus.s_data}, exp_word.pop_front());
        end
      end
    end
  end

  task automatic clear_stats();
    rd_count = 0;
    first_rd = -1;
    last_rd  = -1;
    first_sv = -1;
  endtask

  task automatic send(input logic fc, input logic [AW-1:0] base, input logic [6:0] dim0);
    logic [IRW*IN-1:0] inst;
    logic              got;
    int                len;
    inst       = '0;
    inst[0]    = fc;
    inst[21:8] = base;
    inst[28:22] = dim0;
    len = fc ? 1 : ((dim0 == 7'd0) ? 128 : int'(dim0));
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      exp_addr.push_back(a);
      exp_word.push_back({(i == len - 1), mem_f(a)});
    end
    bus.m_inst  = inst;
    bus.m_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (bus.m_ready) begin
        got     = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    check("accept", 65'(got), 65'd1);
    bus.m_valid = 1'b0;
  endtask

  task automatic drain(input logic rnd);
    for (int t = 0; t < 600 && (exp_word.size() != 0 || exp_addr.size() != 0); t++) begin
      if (rnd) bus.s_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bus.s_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain", 65'(exp_word.size() + exp_addr.size()), 65'd0);
    check("idle_s_valid", 65'(bus.s_valid), 65'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    bus.m_inst  = '0;
    bus.m_valid = 1'b0;
    bus.s_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_ready", 65'(bus.m_ready), 65'd0);
    check("rst_rd_en", 65'(bus.mem_rd_en), 65'd0);
    check("rst_rd_addr", 65'(bus.mem_rd_addr), 65'd0);
    check("rst_s_valid", 65'(bus.s_valid), 65'd0);
    check("rst_s_last", 65'(bus.s_last), 65'd0);
    check("rst_s_data", 65'(bus.s_data), 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_m_ready", 65'(bus.m_ready), 65'd1);
    @(posedge clk);
    #1;

    // Plain 5-word burst with latency checks.
    bus.s_ready = 1'b1;
    clear_stats();
    send(1'b0, 14'h0100, 7'd5);
    drain(1'b0);
    check("b5_count", 65'(rd_count), 65'd5);
    check("b5_consec", 65'(last_rd - first_rd), 65'd4);
    check("b5_rd_lat", 65'(first_rd - acc_cyc), 65'd1);
    check("b5_sv_lat", 65'(first_sv - acc_cyc), 65'd3);

    // fc forces a single read regardless of dim0.
    clear_stats();
    send(1'b1, 14'h0020, 7'd9);
    drain(1'b0);
    check("fc_count", 65'(rd_count), 65'd1);
    check("fc_sv_lat", 65'(first_sv - acc_cyc), 65'd3);

    // Address wrap at the top of the space.
    clear_stats();
    send(1'b0, 14'h3FFE, 7'd3);
    drain(1'b0);
    check("wrap_count", 65'(rd_count), 65'd3);

    // dim0 of zero means 128.
    clear_stats();
    send(1'b0, 14'h1234, 7'd0);
    drain(1'b0);
    check("d128_count", 65'(rd_count), 65'd128);
    check("d128_consec", 65'(last_rd - first_rd), 65'd127);

    // Back-pressure: only FIFO-depth reads go out while stalled.
    clear_stats();
    bus.s_ready = 1'b0;
    send(1'b0, 14'h0500, 7'd10);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("bp_count", 65'(rd_count), 65'd4);
    check("bp_rd_en", 65'(bus.mem_rd_en), 65'd0);
    check("bp_s_valid", 65'(bus.s_valid), 65'd1);
    check("bp_head", {bus.s_last, bus.s_data}, exp_word[0]);
    @(negedge clk);
    check("bp_hold", {bus.s_last, bus.s_data}, exp_word[0]);
    @(posedge clk);
    #1;
    bus.s_ready = 1'b1;
    drain(1'b0);
    check("bp_total", 65'(rd_count), 65'd10);

    // Random stalls across a longer burst.
    clear_stats();
    bus.s_ready = 1'b0;
    send(1'b0, 14'h0A00, 7'd20);
    drain(1'b1);
    check("rnd_count", 65'(rd_count), 65'd20);

    // Back-to-back instructions with no issue gap.
    clear_stats();
    bus.s_ready = 1'b1;
    send(1'b0, 14'h0040, 7'd2);
    send(1'b0, 14'h0080, 7'd3);
    drain(1'b0);
    check("b2b_count", 65'(rd_count), 65'd5);
    check("b2b_consec", 65'(last_rd - first_rd), 65'd4);

    // Asynchronous reset mid-burst.
    clear_stats();
    send(1'b0, 14'h0600, 7'd20);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_s_valid", 65'(bus.s_valid), 65'd0);
    check("mid_rst_rd_en", 65'(bus.mem_rd_en), 65'd0);
    check("mid_rst_m_ready", 65'(bus.m_ready), 65'd0);
    exp_addr.delete();
    exp_word.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_m_ready", 65'(bus.m_ready), 65'd1);
    check("rel_s_valid", 65'(bus.s_valid), 65'd0);
    check("rel_rd_en", 65'(bus.mem_rd_en), 65'd0);
    @(posedge clk);
    #1;
    clear_stats();
    send(1'b0, 14'h0700, 7'd3);
    drain(1'b0);
    check("post_rst_count", 65'(rd_count), 65'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
